// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller for the MEM stage: accepts one aligned
// load or store, stalls the pipeline for LATENCY+1 cycles, then pulses done_o.
module dmem_ctrl #(
    parameter int unsigned LATENCY = 3,
    parameter int unsigned DEPTH   = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  M_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        stall_o,
    output logic [31:0] data_o,
    output logic        done_o,
    output logic        err_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          op_wr;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
    logic [31:0]   mem [DEPTH];

    logic req_any;
    logic req_valid;
    logic unused_addr;

    assign req_any     = |M_i;
    assign req_valid   = (M_i[0] ^ M_i[1]) && (addr_i[1:0] == 2'b00);
    // High address bits are deliberately dropped so accesses wrap modulo DEPTH.
    assign unused_addr = ^addr_i[31:AW+2];

    always_comb begin
        stall_o = (state == BUSY) || ((state == IDLE) && req_valid);
        done_o  = (state == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= '0;
            data_o <= '0;
            err_o  <= 1'b0;
            op_wr  <= 1'b0;
            idx    <= '0;
            wdata  <= '0;
            mem    <= '{default: '0};
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_wr <= M_i[1];
                        idx   <= addr_i[AW+1:2];
                        wdata <= data_i;
                        cnt   <= 4'(LATENCY - 1);
                        state <= BUSY;
                    end else if (req_any) begin
                        err_o <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        if (op_wr) begin
                            mem[idx] <= wdata;
                        end else begin
                            data_o <= mem[idx];
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                // The EX/MEM register still shows the finished request here, so M_i is ignored.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (LATENCY=3, DEPTH=32): vector table of single
// accesses plus hand sequences for hold-through-DONE, BUSY input churn and reset.
module tb_dmem_ctrl;

    localparam int unsigned LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m;
    logic [31:0] addr;
    logic [31:0] data;
    logic        stall;
    logic [31:0] data_out;
    logic        done;
    logic        err;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_ctrl #(.LATENCY(LAT), .DEPTH(32)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .M_i     (m),
        .addr_i  (addr),
        .data_i  (data),
        .stall_o (stall),
        .data_o  (data_out),
        .done_o  (done),
        .err_o   (err)
    );

    // kind: 0 = valid access, 1 = rejected request, 2 = no-op
    typedef struct {
        logic [1:0]  m;
        logic [31:0] addr;
        logic [31:0] data;
        int          kind;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic [1:0] mm, input logic [31:0] a,
                                input logic [31:0] d, input int k, input logic [31:0] e);
        vec_t v;
        v.m = mm; v.addr = a; v.data = d; v.kind = k; v.exp_data = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int stall_cnt;
        int done_cyc;
        int err_seen;
        @(posedge clk); #1;
        m = v.m; addr = v.addr; data = v.data;
        if (v.kind == 0) begin
            stall_cnt = 0; done_cyc = -1; err_seen = 0;
            for (int c = 0; c < 40 && done_cyc < 0; c++) begin
                @(negedge clk);
                if (stall) stall_cnt++;
                if (err) err_seen++;
                if (done) done_cyc = c;
            end
            check({tag, "_data"}, data_out, v.exp_data);
            @(posedge clk); #1;
            m = 2'b00;
            check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(LAT + 1));
            check({tag, "_done_cycle"}, 32'(done_cyc), 32'(LAT + 1));
            check({tag, "_no_err"}, 32'(err_seen), 32'd0);
        end else begin
            @(negedge clk);
            check({tag, "_stall0"}, {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
            m = 2'b00;
            @(negedge clk);
            check({tag, "_err"}, {31'd0, err}, (v.kind == 1) ? 32'd1 : 32'd0);
            check({tag, "_stall1"}, {31'd0, stall}, 32'd0);
            check({tag, "_data"}, data_out, v.exp_data);
        end
    endtask

    initial begin
        int dones;
        int stalls;
        int done_cyc;

        vecs[0]  = mk(2'b10, 32'h0000_0008, 32'hDEAD_BEEF, 0, 32'h0000_0000);
        vecs[1]  = mk(2'b01, 32'h0000_0008, 32'h0000_0000, 0, 32'hDEAD_BEEF);
        vecs[2]  = mk(2'b10, 32'h0000_0000, 32'h1111_1111, 0, 32'hDEAD_BEEF);
        vecs[3]  = mk(2'b01, 32'h0000_0080, 32'h0000_0000, 0, 32'h1111_1111);
        vecs[4]  = mk(2'b01, 32'h0000_0006, 32'h0000_0000, 1, 32'h1111_1111);
        vecs[5]  = mk(2'b11, 32'h0000_0004, 32'h5555_5555, 1, 32'h1111_1111);
        vecs[6]  = mk(2'b00, 32'h0000_0000, 32'h0000_0000, 2, 32'h1111_1111);
        vecs[7]  = mk(2'b01, 32'h0000_0004, 32'h0000_0000, 0, 32'h0000_0000);
        vecs[8]  = mk(2'b10, 32'h0000_0009, 32'hFFFF_FFFF, 1, 32'h0000_0000);
        vecs[9]  = mk(2'b01, 32'h0000_0008, 32'h0000_0000, 0, 32'hDEAD_BEEF);
        vecs[10] = mk(2'b10, 32'hFFFF_FFFC, 32'hCAFE_F00D, 0, 32'hDEAD_BEEF);
        vecs[11] = mk(2'b01, 32'h0000_007C, 32'h0000_0000, 0, 32'hCAFE_F00D);

        rst = 1'b1; m = 2'b00; addr = '0; data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_data", data_out, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end

        // Read held on M_i through DONE: one access, one done pulse
        @(posedge clk); #1;
        m = 2'b01; addr = 32'h0000_0008;
        dones = 0; stalls = 0;
        for (int c = 0; c <= int'(LAT) + 1; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        @(posedge clk); #1;
        m = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) dones++;
            if (stall) stalls++;
        end
        check("hold_done_count", 32'(dones), 32'd1);
        check("hold_idle_stall", 32'(stalls), 32'd0);
        check("hold_data", data_out, 32'hDEAD_BEEF);
        run_vec(mk(2'b01, 32'h0000_0000, 32'h0, 0, 32'h1111_1111), "fresh_rd");

        // Write whose inputs churn every cycle after acceptance
        @(posedge clk); #1;
        m = 2'b10; addr = 32'h0000_000C; data = 32'hA5A5_A5A5;
        done_cyc = -1;
        for (int c = 0; c <= int'(LAT) + 1; c++) begin
            @(negedge clk);
            if (done && done_cyc < 0) done_cyc = c;
            @(posedge clk); #1;
            if (c == int'(LAT) + 1) begin
                m = 2'b00;
            end else begin
                m    = (c % 2 == 0) ? 2'b01 : 2'b10;
                addr = 32'h0000_0010 + 32'(c * 4);
                data = 32'h0BAD_0000 + 32'(c);
            end
        end
        check("churn_done_cycle", 32'(done_cyc), 32'(LAT + 1));
        run_vec(mk(2'b01, 32'h0000_0014, 32'h0, 0, 32'h0000_0000), "churn_rd14");
        run_vec(mk(2'b01, 32'h0000_000C, 32'h0, 0, 32'hA5A5_A5A5), "churn_rd0c");

        // Reset in the second BUSY cycle of a write discards it
        @(posedge clk); #1;
        m = 2'b10; addr = 32'h0000_0010; data = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; m = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_stall", {31'd0, stall}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        check("midrst_data", data_out, 32'd0);
        @(negedge clk);
        check("midrst_no_late_done", {31'd0, done}, 32'd0);
        run_vec(mk(2'b01, 32'h0000_000C, 32'h0, 0, 32'h0000_0000), "midrst_rd0c");
        run_vec(mk(2'b01, 32'h0000_0010, 32'h0, 0, 32'h0000_0000), "midrst_rd10");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
